// File: rtl/associative_tag_lookup_ctrl_pkg.sv
// Shared types and constants for the associative tag lookup controller.
// Provides the byte width used for write masks and the FSM state encoding.
package associative_tag_lookup_ctrl_pkg;

  localparam int BYTE_LEN_IN_BITS = 8;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_READ = 3'd2,
    ST_CMP  = 3'd3,
    ST_FILL = 3'd4,
    ST_RESP = 3'd5
  } state_t;

endpackage

// File: rtl/associative_tag_lookup_ctrl_way_victim_select.sv
// Victim way picker: lowest-index invalid way, else the round-robin way.
// Ports: valid_in (per-way valid), rr_ptr_in -> victim_out (one-hot), victim_idx_out, evict_valid_out.
module way_victim_select #(
  parameter int NUM_WAY = 16,
  parameter int PTR_W   = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1
) (
  input  logic [NUM_WAY-1:0] valid_in,
  input  logic [PTR_W-1:0]   rr_ptr_in,
  output logic [NUM_WAY-1:0] victim_out,
  output logic [PTR_W-1:0]   victim_idx_out,
  output logic               evict_valid_out
);

  always_comb begin
    victim_out      = '0;
    victim_idx_out  = rr_ptr_in;
    evict_valid_out = &valid_in;
    // descending scan so the lowest invalid way wins
    for (int g = NUM_WAY - 1; g >= 0; g--) begin
      if (!valid_in[g]) victim_idx_out = PTR_W'(g);
    end
    victim_out[victim_idx_out] = 1'b1;
  end

endmodule

// File: rtl/associative_tag_lookup_ctrl.sv
// Request-side controller for a {valid,tag} associative array: sweeps, looks up, allocates.
// Ports: clk_in/reset_in, req_* / resp_* handshakes, init_done_out, array_* to/from the tag array.
module associative_tag_lookup_ctrl
  import associative_tag_lookup_ctrl_pkg::*;
#(
  parameter int NUM_SET               = 64,
  parameter int NUM_WAY               = 16,
  parameter int TAG_WIDTH             = 20,
  parameter int ENTRY_SIZE_IN_BITS    = 32,
  parameter int SET_PTR_WIDTH_IN_BITS = $clog2(NUM_SET) + 1,
  parameter int WRITE_MASK_LEN        = ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS
) (
  input  logic                                    clk_in,
  input  logic                                    reset_in,
  output logic                                    init_done_out,
  input  logic                                    req_valid_in,
  output logic                                    req_ready_out,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]        req_set_in,
  input  logic [TAG_WIDTH-1:0]                    req_tag_in,
  input  logic                                    req_fill_in,
  output logic                                    resp_valid_out,
  input  logic                                    resp_ready_in,
  output logic                                    resp_hit_out,
  output logic [NUM_WAY-1:0]                      resp_way_out,
  output logic                                    resp_evict_valid_out,
  output logic [TAG_WIDTH-1:0]                    resp_evict_tag_out,
  output logic                                    array_access_en_out,
  output logic [WRITE_MASK_LEN-1:0]               array_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]        array_set_addr_out,
  output logic [NUM_WAY-1:0]                      array_way_select_out,
  output logic [ENTRY_SIZE_IN_BITS-1:0]           array_write_entry_out,
  input  logic [ENTRY_SIZE_IN_BITS*NUM_WAY-1:0]   array_read_set_in
);

  localparam int E     = ENTRY_SIZE_IN_BITS;
  localparam int SW    = SET_PTR_WIDTH_IN_BITS;
  localparam int PTR_W = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;
  localparam logic [SW-1:0]    LAST_SET = SW'(NUM_SET - 1);
  localparam logic [SW-1:0]    SET_LIM  = SW'(NUM_SET);
  localparam logic [PTR_W-1:0] LAST_WAY = PTR_W'(NUM_WAY - 1);

  state_t                 state_q, state_d;
  logic                   active_q;
  logic [SW-1:0]          init_cnt_q;
  logic [SW-1:0]          set_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic                   fill_q;
  logic [PTR_W-1:0]       rr_q;
  logic [NUM_WAY-1:0]     victim_q;

  logic [NUM_WAY-1:0]     way_valid, hit_vec, hit_first;
  logic [NUM_WAY-1:0]     vic_oh;
  logic [PTR_W-1:0]       vic_idx;
  logic                   vic_evict;
  logic [TAG_WIDTH-1:0]   vic_tag;
  logic                   set_oor;
  logic                   unused_pad;

  assign unused_pad = ^array_read_set_in;
  assign set_oor    = req_set_in >= SET_LIM;

  always_comb begin
    way_valid = '0;
    hit_vec   = '0;
    vic_tag   = '0;
    for (int g = 0; g < NUM_WAY; g++) begin
      way_valid[g] = array_read_set_in[g*E + TAG_WIDTH];
      hit_vec[g]   = way_valid[g] &&
                     (array_read_set_in[g*E +: TAG_WIDTH] == tag_q);
      if (PTR_W'(g) == vic_idx)
        vic_tag = array_read_set_in[g*E +: TAG_WIDTH];
    end
  end

  // isolate the lowest set bit
  assign hit_first = hit_vec & (~hit_vec + NUM_WAY'(1));

  way_victim_select #(
    .NUM_WAY (NUM_WAY),
    .PTR_W   (PTR_W)
  ) u_victim (
    .valid_in        (way_valid),
    .rr_ptr_in       (rr_q),
    .victim_out      (vic_oh),
    .victim_idx_out  (vic_idx),
    .evict_valid_out (vic_evict)
  );

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q              <= ST_INIT;
      active_q             <= 1'b0;
      init_cnt_q           <= '0;
      init_done_out        <= 1'b0;
      set_q                <= '0;
      tag_q                <= '0;
      fill_q               <= 1'b0;
      rr_q                 <= '0;
      victim_q             <= '0;
      resp_hit_out         <= 1'b0;
      resp_way_out         <= '0;
      resp_evict_valid_out <= 1'b0;
      resp_evict_tag_out   <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
      unique case (state_q)
        ST_INIT: begin
          if (active_q) begin
            init_cnt_q <= (init_cnt_q == LAST_SET) ? '0
                        : init_cnt_q + SW'(1);
            if (init_cnt_q == LAST_SET) init_done_out <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid_in) begin
            set_q                <= req_set_in;
            tag_q                <= req_tag_in;
            fill_q               <= req_fill_in;
            resp_hit_out         <= 1'b0;
            resp_way_out         <= '0;
            resp_evict_valid_out <= 1'b0;
            resp_evict_tag_out   <= '0;
          end
        end
        ST_CMP: begin
          if (|hit_vec) begin
            resp_hit_out <= 1'b1;
            resp_way_out <= hit_first;
          end else if (fill_q) begin
            victim_q             <= vic_oh;
            resp_way_out         <= vic_oh;
            resp_evict_valid_out <= vic_evict;
            resp_evict_tag_out   <= vic_evict ? vic_tag : '0;
          end
        end
        ST_FILL: begin
          if (resp_evict_valid_out)
            rr_q <= (rr_q == LAST_WAY) ? '0 : rr_q + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: if (active_q && init_cnt_q == LAST_SET) state_d = ST_IDLE;
      ST_IDLE: if (req_valid_in) state_d = set_oor ? ST_RESP : ST_READ;
      ST_READ: state_d = ST_CMP;
      ST_CMP:  state_d = (|hit_vec || !fill_q) ? ST_RESP : ST_FILL;
      ST_FILL: state_d = ST_RESP;
      ST_RESP: if (resp_ready_in) state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    req_ready_out         = 1'b0;
    resp_valid_out        = 1'b0;
    array_access_en_out   = 1'b0;
    array_write_en_out    = '0;
    array_set_addr_out    = '0;
    array_way_select_out  = '0;
    array_write_entry_out = '0;
    unique case (state_q)
      ST_INIT: begin
        // held quiet until the first cycle out of reset
        if (active_q) begin
          array_access_en_out  = 1'b1;
          array_write_en_out   = '1;
          array_way_select_out = '1;
          array_set_addr_out   = init_cnt_q;
        end
      end
      ST_IDLE: req_ready_out = 1'b1;
      ST_READ: begin
        array_access_en_out  = 1'b1;
        array_way_select_out = '1;
        array_set_addr_out   = set_q;
      end
      ST_FILL: begin
        array_access_en_out   = 1'b1;
        array_write_en_out    = '1;
        array_way_select_out  = victim_q;
        array_set_addr_out    = set_q;
        array_write_entry_out = E'({1'b1, tag_q});
      end
      ST_RESP: resp_valid_out = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in && state_q == ST_CMP)
      assert ($onehot0(hit_vec))
      else $error("tag matched in more than one way");
  end

endmodule

// File: tb/tb_associative_tag_lookup_ctrl.sv
// Self-checking bench for associative_tag_lookup_ctrl with a behavioural tag array.
// Vector table plus hand sequences; responses checked through a scoreboard queue.
module tb_associative_tag_lookup_ctrl;

  localparam int NW = 16;
  localparam int TW = 20;
  localparam int E  = 32;
  localparam int SW = 7;
  localparam int WM = 4;

  logic            clk = 1'b0;
  logic            reset_in;
  logic            init_done_out;
  logic            req_valid_in;
  logic            req_ready_out;
  logic [SW-1:0]   req_set_in;
  logic [TW-1:0]   req_tag_in;
  logic            req_fill_in;
  logic            resp_valid_out;
  logic            resp_ready_in;
  logic            resp_hit_out;
  logic [NW-1:0]   resp_way_out;
  logic            resp_evict_valid_out;
  logic [TW-1:0]   resp_evict_tag_out;
  logic            array_access_en_out;
  logic [WM-1:0]   array_write_en_out;
  logic [SW-1:0]   array_set_addr_out;
  logic [NW-1:0]   array_way_select_out;
  logic [E-1:0]    array_write_entry_out;
  logic [E*NW-1:0] rd_q;

  always #5 clk = ~clk;

  associative_tag_lookup_ctrl dut (
    .clk_in                (clk),
    .reset_in              (reset_in),
    .init_done_out         (init_done_out),
    .req_valid_in          (req_valid_in),
    .req_ready_out         (req_ready_out),
    .req_set_in            (req_set_in),
    .req_tag_in            (req_tag_in),
    .req_fill_in           (req_fill_in),
    .resp_valid_out        (resp_valid_out),
    .resp_ready_in         (resp_ready_in),
    .resp_hit_out          (resp_hit_out),
    .resp_way_out          (resp_way_out),
    .resp_evict_valid_out  (resp_evict_valid_out),
    .resp_evict_tag_out    (resp_evict_tag_out),
    .array_access_en_out   (array_access_en_out),
    .array_write_en_out    (array_write_en_out),
    .array_set_addr_out    (array_set_addr_out),
    .array_way_select_out  (array_way_select_out),
    .array_write_entry_out (array_write_entry_out),
    .array_read_set_in     (rd_q)
  );

  // tag array model: read data appears one cycle after access
  logic [E-1:0] mem [128][NW];
  logic         preload = 1'b1;
  int           acc_cnt = 0;

  always @(posedge clk) begin
    if (preload) begin
      // stale valid entries; set 5 way 0 holds tag 0x123
      for (int s = 0; s < 128; s++)
        for (int w = 0; w < NW; w++)
          mem[s][w] <= 32'h0010_0000 | 32'(20'h00123 + 20'(w));
    end else if (array_access_en_out) begin
      acc_cnt <= acc_cnt + 1;
      if (|array_write_en_out) begin
        for (int w = 0; w < NW; w++)
          if (array_way_select_out[w])
            for (int b = 0; b < WM; b++)
              if (array_write_en_out[b])
                mem[array_set_addr_out][w][b*8 +: 8]
                  <= array_write_entry_out[b*8 +: 8];
      end else begin
        for (int w = 0; w < NW; w++)
          rd_q[w*E +: E] <= mem[array_set_addr_out][w];
      end
    end
  end

  typedef struct packed {
    logic          hit;
    logic [NW-1:0] way;
    logic          ev;
    logic [TW-1:0] evtag;
  } exp_t;

  typedef struct {
    logic [SW-1:0] set;
    logic [TW-1:0] tag;
    logic          fill;
    logic          hit;
    logic [NW-1:0] way;
    logic          ev;
    logic [TW-1:0] evtag;
    int            lat;
  } vec_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t cur_resp();
    return {resp_hit_out, resp_way_out,
            resp_evict_valid_out, resp_evict_tag_out};
  endfunction

  function automatic logic [11:0] outs();
    return {init_done_out, req_ready_out, resp_valid_out,
            resp_hit_out, resp_evict_valid_out,
            array_access_en_out, |array_write_en_out,
            |array_way_select_out, |array_set_addr_out,
            |array_write_entry_out, |resp_way_out,
            |resp_evict_tag_out};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!req_ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", 64'(req_ready_out), 64'd1);
  endtask

  task automatic check_init();
    int n = 0;
    while (!array_access_en_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("init_write_%0d", k),
          64'({array_access_en_out, array_write_en_out,
               array_way_select_out, array_set_addr_out,
               array_write_entry_out, init_done_out}),
          64'({1'b1, 4'hF, 16'hFFFF, 7'(k), 32'h0, 1'b0}));
      @(negedge clk);
    end
    chk("init_done", 64'({init_done_out, req_ready_out,
                          array_access_en_out}), 64'(3'b110));
  endtask

  task automatic run_req(input vec_t v, input int hold);
    exp_t e;
    int   lat;
    int   acc0;
    int   exp_acc;
    resp_ready_in = (hold == 0);
    wait_ready();
    sbq.push_back({v.hit, v.way, v.ev, v.evtag});
    acc0         = acc_cnt;
    req_valid_in = 1'b1;
    req_set_in   = v.set;
    req_tag_in   = v.tag;
    req_fill_in  = v.fill;
    @(negedge clk);
    req_valid_in = 1'b0;
    lat = 1;
    while (!resp_valid_out && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    exp_acc = (v.lat == 1) ? 0 : v.lat - 2;
    chk($sformatf("latency_set%0d_tag%0h", v.set, v.tag),
        64'(lat), 64'(v.lat));
    chk("array_accesses", 64'(acc_cnt - acc0), 64'(exp_acc));
    e = sbq.pop_front();
    chk($sformatf("resp_set%0d_tag%0h", v.set, v.tag),
        64'(cur_resp()), 64'(e));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_resp", 64'(cur_resp()), 64'(e));
      chk("hold_busy", 64'({resp_valid_out, req_ready_out}),
          64'(2'b10));
    end
    resp_ready_in = 1'b1;
    @(negedge clk);
    chk("resp_done", 64'({resp_valid_out, req_ready_out}),
        64'(2'b01));
  endtask

  vec_t vt[12];
  vec_t v;

  initial begin
    reset_in      = 1'b0;
    req_valid_in  = 1'b0;
    req_set_in    = '0;
    req_tag_in    = '0;
    req_fill_in   = 1'b0;
    resp_ready_in = 1'b1;

    vt[0]  = '{7'd5,   20'h123,   1'b0, 1'b0, 16'h0000, 1'b0, 20'h0, 3};
    vt[1]  = '{7'd5,   20'h123,   1'b1, 1'b0, 16'h0001, 1'b0, 20'h0, 4};
    vt[2]  = '{7'd5,   20'h123,   1'b0, 1'b1, 16'h0001, 1'b0, 20'h0, 3};
    vt[3]  = '{7'd5,   20'h456,   1'b1, 1'b0, 16'h0002, 1'b0, 20'h0, 4};
    vt[4]  = '{7'd5,   20'h456,   1'b0, 1'b1, 16'h0002, 1'b0, 20'h0, 3};
    vt[5]  = '{7'd5,   20'h123,   1'b1, 1'b1, 16'h0001, 1'b0, 20'h0, 3};
    vt[6]  = '{7'd6,   20'h123,   1'b0, 1'b0, 16'h0000, 1'b0, 20'h0, 3};
    vt[7]  = '{7'd64,  20'h123,   1'b1, 1'b0, 16'h0000, 1'b0, 20'h0, 1};
    vt[8]  = '{7'd127, 20'h00000, 1'b0, 1'b0, 16'h0000, 1'b0, 20'h0, 1};
    vt[9]  = '{7'd63,  20'hFFFFF, 1'b1, 1'b0, 16'h0001, 1'b0, 20'h0, 4};
    vt[10] = '{7'd63,  20'hFFFFF, 1'b0, 1'b1, 16'h0001, 1'b0, 20'h0, 3};
    vt[11] = '{7'd0,   20'h00000, 1'b0, 1'b0, 16'h0000, 1'b0, 20'h0, 3};

    repeat (3) @(negedge clk);
    preload = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("reset_outputs", 64'(outs()), 64'd0);
    end
    reset_in = 1'b1;
    check_init();

    for (int i = 0; i < 12; i++) run_req(vt[i], 0);

    // 16 fills populate set 9, the 17th and 18th evict round-robin
    for (int i = 0; i < 18; i++) begin
      v.set   = 7'd9;
      v.tag   = 20'h100 + 20'(i);
      v.fill  = 1'b1;
      v.hit   = 1'b0;
      v.lat   = 4;
      v.way   = (i < 16) ? (16'(1) << i)
              : ((i == 16) ? 16'h0001 : 16'h0002);
      v.ev    = (i >= 16);
      v.evtag = (i == 16) ? 20'h100
              : ((i == 17) ? 20'h101 : 20'h0);
      run_req(v, 0);
      if (i == 16) begin
        run_req('{7'd9, 20'h110, 1'b0, 1'b1, 16'h0001,
                  1'b0, 20'h0, 3}, 0);
        run_req('{7'd9, 20'h100, 1'b0, 1'b0, 16'h0000,
                  1'b0, 20'h0, 3}, 0);
      end
    end

    run_req('{7'd5, 20'h456, 1'b0, 1'b1, 16'h0002,
              1'b0, 20'h0, 3}, 5);

    // reset lands while the fill write is on the array bus
    resp_ready_in = 1'b1;
    wait_ready();
    req_valid_in = 1'b1;
    req_set_in   = 7'd12;
    req_tag_in   = 20'hABC;
    req_fill_in  = 1'b1;
    @(negedge clk);
    req_valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("in_fill_write", 64'({array_access_en_out,
                              array_write_en_out}), 64'(5'h1F));
    reset_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_in_fill_outputs", 64'(outs()), 64'd0);
    end
    reset_in = 1'b1;
    check_init();
    run_req('{7'd12, 20'hABC, 1'b0, 1'b0, 16'h0000,
              1'b0, 20'h0, 3}, 0);
    run_req('{7'd64, 20'hABC, 1'b0, 1'b0, 16'h0000,
              1'b0, 20'h0, 1}, 0);

    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
